// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller.
// The bench also uses the latency helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        TRIAL,
        DONE
    } sar_state_e;

    // Clocks spent on each trial bit: DAC/comparator settling plus synchronizer delay.
    function automatic int trial_window(int settle, int sync);
        return settle + sync;
    endfunction

    function automatic int cnt_width(int settle, int sync);
        int m;
        m = (settle > settle + sync) ? settle : settle + sync;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Number of edges from the edge that accepts start to the start of the done cycle.
    function automatic int latency(int width, int settle, int sync);
        return 1 + settle + width * (settle + sync);
    endfunction

endpackage

// File: rtl/sar_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs such as
// the latched comparator output.
module sar_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, then runs an MSB-first
// binary search against the synchronized comparator, one bit per trial window.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int W     = trial_window(SETTLE_CYCLES, SYNC_STAGES);
    localparam int CNT_W = cnt_width(SETTLE_CYCLES, SYNC_STAGES);
    localparam int IDX_W = idx_width(WIDTH);

    sar_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             cmp_sync;

    sar_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SAMPLE;
            SAMPLE:  if (cnt == '0) state_next = TRIAL;
            TRIAL:   if (cnt == '0 && idx == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sample = (state == SAMPLE);

    // Datapath. The comparator is only consulted when the trial counter expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            valid    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        dac_code <= '0;
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        cnt                 <= CNT_W'(W - 1);
                        idx                 <= IDX_W'(WIDTH - 1);
                        dac_code[WIDTH-1]   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TRIAL: begin
                    if (cnt == '0) begin
                        dac_code[idx] <= cmp_sync;
                        if (idx != '0) begin
                            dac_code[idx - 1'b1] <= 1'b1;
                            idx                  <= idx - 1'b1;
                            cnt                  <= CNT_W'(W - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    result   <= dac_code;
                    done     <= 1'b1;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    dac_code <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: table of conversions against a comparator
// model, plus hand sequences for back-to-back starts and mid-conversion reset.
module tb_sar_adc_ctrl;
    import sar_pkg::*;

    localparam int WIDTH = 8;
    localparam int S     = 4;
    localparam int SYNC  = 2;
    localparam int W     = S + SYNC;
    localparam int LAT   = latency(WIDTH, S, SYNC);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cmp_in = 1'b0;
    logic             sample;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             valid;

    int checks = 0;
    int errors = 0;

    // Per-run observations filled by run_conv.
    int         first_done, second_done, ndone;
    int         busy_err, sample_err, trace_err, valid_err;
    logic [7:0] got_trace [8];

    sar_adc_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] analog;
        bit         glitch;
        bit         extra;
        logic [7:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One conversion. rst_at >= 0 pulls reset at that cycle and stops early.
    // hold keeps start high so a second conversion follows immediately.
    task automatic run_conv(input logic [7:0] analog, input bit glitch, input bit extra,
                            input int rst_at, input bit hold);
        logic [7:0] code, trial;
        logic [7:0] exp_trace [8];
        int         ncyc, k;
        code = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            trial = code | (8'h01 << b);
            exp_trace[7-b] = trial;
            if (analog >= trial) code = trial;
        end
        first_done = -1; second_done = -1; ndone = 0;
        busy_err = 0; sample_err = 0; trace_err = 0; valid_err = 0;
        for (int i = 0; i < 8; i++) got_trace[i] = 8'h00;
        ncyc = hold ? 2 * LAT + 6 : LAT + 5;

        @(negedge clk);
        start  = 1'b1;
        cmp_in = (analog >= dac_code);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            #1;
            if (hold) start = (n < LAT + 1);
            else      start = extra && (n == 9 || n == 29);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_busy",   busy, 0);
                chk("rst_mid_done",   done, 0);
                chk("rst_mid_sample", sample, 0);
                chk("rst_mid_dac",    dac_code, 0);
                chk("rst_mid_result", result, 0);
                chk("rst_mid_valid",  valid, 0);
                start = 1'b0;
                return;
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
            if (n <= LAT) begin
                if (busy !== (n < LAT)) busy_err++;
                if (sample !== (n < S)) sample_err++;
                if (valid !== (n == LAT)) valid_err++;
            end
            if (n >= S && n < S + 8 * W && (n - S) % W == 0) begin
                k = (n - S) / W;
                got_trace[k] = dac_code;
                if (dac_code !== exp_trace[k]) trace_err++;
            end
            @(negedge clk);
            if (glitch && n >= S && ((n - S) % W) < W - SYNC - 1)
                cmp_in = ~cmp_in;
            else
                cmp_in = (analog >= dac_code);
        end
        start = 1'b0;
    endtask

    vec_t       vecs [5];
    logic [7:0] trace_a5 [8];

    initial begin
        vecs[0] = '{analog: 8'hA5, glitch: 1'b0, extra: 1'b0, exp_result: 8'hA5};
        vecs[1] = '{analog: 8'hFF, glitch: 1'b0, extra: 1'b0, exp_result: 8'hFF};
        vecs[2] = '{analog: 8'h00, glitch: 1'b0, extra: 1'b0, exp_result: 8'h00};
        vecs[3] = '{analog: 8'hA5, glitch: 1'b0, extra: 1'b1, exp_result: 8'hA5};
        vecs[4] = '{analog: 8'h5A, glitch: 1'b1, extra: 1'b0, exp_result: 8'h5A};
        trace_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset state and quiet idle after release.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   busy, 0);
        chk("reset_done",   done, 0);
        chk("reset_sample", sample, 0);
        chk("reset_dac",    dac_code, 0);
        chk("reset_result", result, 0);
        chk("reset_valid",  valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; busy_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy !== 1'b0 || sample !== 1'b0 || dac_code !== 8'h00) busy_err++;
        end
        chk("idle_no_done", ndone, 0);
        chk("idle_quiet",   busy_err, 0);

        for (int v = 0; v < 5; v++) begin
            run_conv(vecs[v].analog, vecs[v].glitch, vecs[v].extra, -1, 1'b0);
            chk($sformatf("v%0d_done_cycle", v), first_done, LAT);
            chk($sformatf("v%0d_done_count", v), ndone, 1);
            chk($sformatf("v%0d_result", v),     result, vecs[v].exp_result);
            chk($sformatf("v%0d_valid", v),      valid, 1);
            chk($sformatf("v%0d_busy", v),       busy_err, 0);
            chk($sformatf("v%0d_sample", v),     sample_err, 0);
            chk($sformatf("v%0d_valid_prof", v), valid_err, 0);
            chk($sformatf("v%0d_trace", v),      trace_err, 0);
            if (v == 0)
                for (int i = 0; i < 8; i++)
                    chk($sformatf("a5_trace%0d", i), got_trace[i], trace_a5[i]);
        end

        // Start held high: second conversion accepted the cycle after done.
        run_conv(8'h33, 1'b0, 1'b0, -1, 1'b1);
        chk("b2b_first_done",  first_done, LAT);
        chk("b2b_second_done", second_done, 2 * LAT + 1);
        chk("b2b_done_count",  ndone, 2);
        chk("b2b_result",      result, 8'h33);

        // Reset at cycle 25 of a conversion, then a clean conversion.
        run_conv(8'h77, 1'b0, 1'b0, 25, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; busy_err = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy !== 1'b0) busy_err++;
        end
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_idle",    busy_err, 0);
        chk("post_rst_result",  result, 0);
        run_conv(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        chk("after_rst_done_cycle", first_done, LAT);
        chk("after_rst_result",     result, 8'h3C);
        chk("after_rst_valid",      valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation controller that directly consumes the output of the latched analog comparator on the tile.
- Drives the sample switch and the binary-weighted DAC code that sets the comparator's reference input.
- Runs one MSB-first binary search per start request and delivers a registered WIDTH-bit result with a done pulse.
- Sits between the comparator and the tile's digital output pins.

Parameters:
- WIDTH, 8: conversion resolution in bits; legal range 2..12.
- SETTLE_CYCLES, 4: clocks allowed for DAC/comparator settling per phase; legal range ≥1.
- SYNC_STAGES, 2: flip-flop depth of the comparator input synchronizer; legal range ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  conversion request; level-sampled in IDLE only
- cmp_in  in  1  raw comparator output, asynchronous to clk; 1 = analog input above DAC level
- sample  out  1  sample switch enable; high during the SAMPLE phase
- dac_code  out  WIDTH  trial code driving the DAC
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse when result updates
- result  out  WIDTH  last completed conversion, held until the next done
- valid  out  1  set by done; cleared when the next start is accepted

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous assert, synchronous deassert at the tile top. Reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.
- cmp_in handling: passes through a SYNC_STAGES flip-flop chain. Only the synchronized value is ever used. Define W = SETTLE_CYCLES + SYNC_STAGES.
- State IDLE: sample=0, busy=0, dac_code=0. If start=1 at an edge: go to SAMPLE, clear valid, set busy.
- State SAMPLE: sample=1 and dac_code=0 for exactly SETTLE_CYCLES cycles. Then go to TRIAL with bit index i=WIDTH-1.
- State TRIAL:
  - On entry, dac_code[i] is set to 1; bits above i hold their decided values; bits below i are 0.
  - Hold for W cycles, counted by a settle counter.
  - On the last cycle, read the synchronized comparator: 1 keeps bit i, 0 clears it.
  - If i=0, go to DONE; otherwise decrement i and re-enter TRIAL.
- State DONE (one cycle): result<=dac_code, done=1, valid<=1, busy<=0. Next state IDLE; dac_code returns to 0 on that transition.
- Latency: done is high in the cycle that begins 1+SETTLE_CYCLES+WIDTH*W edges after the edge that sampled start. With defaults this is 53.
- Back-to-back conversions: start held high re-triggers from IDLE on the cycle after DONE. No start is lost or duplicated.
- Ignored starts: start in any non-IDLE state is ignored and not queued.
- Comparator input outside decision edges: cmp_in changes have no effect except on the decision edge of each TRIAL.
- Reset mid-conversion: return to IDLE immediately. result and valid clear to 0. No done pulse.
- Widths: the settle counter is sized for max(SETTLE_CYCLES, W). The bit index is clog2(WIDTH) wide. There is no arithmetic overflow path.

Decomposition:
- Package sar_pkg holds:
  - the state enum: IDLE, SAMPLE, TRIAL, DONE
  - clog2-based width helper constants
  - the latency formula as a localparam function, shared with the bench
- Sub-module sar_sync: parameterized SYNC_STAGES flop chain with async reset. It is reused for any other async comparator input on the tile.

Test Plan:
- Reset: assert rst_n=0 mid-idle -> all outputs 0. After release, nothing happens until start.
- Comparator model with analog code 0xA5, single start pulse -> dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. done at cycle 53, result=0xA5, valid=1.
- Extremes: analog 0xFF -> result 0xFF; analog 0x00 -> result 0x00; both with exactly one done pulse each.
- Start pulsed at cycles 10 and 30 after the first accepted start -> ignored; one done at 53, busy never drops early.
- rst_n low at cycle 25 of a conversion -> IDLE, result=0, valid=0, no done; a fresh start then converts 0x3C correctly.
- Glitch immunity: cmp_in toggled every cycle except the last SYNC_STAGES+1 cycles before each decision edge, where it holds the model value -> result still equals the model code 0x5A.
